// File: rtl/fpga_input_conditioner.sv
// Synchronizes and debounces board buttons/switches, optionally emitting edge pulses.
// Edge pulse outputs are built only when LOTR_INPUT_EDGE_PULSE_EN is defined.
module fpga_input_conditioner #(
    parameter int              N_IN            = 12,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter int              CNT_W           = 16,
    parameter logic [N_IN-1:0] RST_VAL         = 12'h003
) (
    input  logic            QClk,
    input  logic            RstQnnnL,
    input  logic [N_IN-1:0] in_raw,
    output logic [N_IN-1:0] in_stable,
    output logic [N_IN-1:0] in_rise,
    output logic [N_IN-1:0] in_fall,
    output logic            any_change
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  sync1_q;
    logic [N_IN-1:0]  sync2_q;
    logic [N_IN-1:0]  stable_q;
    logic [N_IN-1:0]  stable_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == TERM_CNT) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            stable_q <= RST_VAL;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_stable = stable_q;

`ifdef LOTR_INPUT_EDGE_PULSE_EN
    logic [N_IN-1:0] stable_prev_q;
    logic [N_IN-1:0] rise_q;
    logic [N_IN-1:0] rise_d;
    logic [N_IN-1:0] fall_q;
    logic [N_IN-1:0] fall_d;
    logic            any_q;
    logic            any_d;

    always_comb begin
        rise_d = stable_q & ~stable_prev_q;
        fall_d = ~stable_q & stable_prev_q;
        any_d  = |(rise_d | fall_d);
    end

    // stable_prev resets with stable so reset entry/exit never looks like an edge.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            stable_prev_q <= RST_VAL;
            rise_q        <= '0;
            fall_q        <= '0;
            any_q         <= 1'b0;
        end else begin
            stable_prev_q <= stable_q;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            any_q         <= any_d;
        end
    end

    assign in_rise    = rise_q;
    assign in_fall    = fall_q;
    assign any_change = any_q;
`else
    assign in_rise    = '0;
    assign in_fall    = '0;
    assign any_change = 1'b0;
`endif

endmodule
